// File: rtl/pong_renderer_gen2.sv
// rtl/pong_renderer_gen2.sv - Pong video timing, frame snapshot and 2-stage pixel pipeline
// Optional dashed centre net: define CENTER_NET_EN.
module pong_renderer_gen2 #(
  parameter int         H_ACTIVE  = 640,
  parameter int         H_FP      = 16,
  parameter int         H_SYNC    = 96,
  parameter int         H_BP      = 48,
  parameter int         V_ACTIVE  = 480,
  parameter int         V_FP      = 10,
  parameter int         V_SYNC    = 2,
  parameter int         V_BP      = 33,
  parameter bit         SYNC_POL  = 1'b0,
  parameter int         XW        = 10,
  parameter int         YW        = 9,
  parameter int         CW        = 8,
  parameter int         PAD_DIST  = 16,
  parameter int         PAD_W     = 8,
  parameter int         PAD_H     = 64,
  parameter int         BALL_SIZE = 8,
  parameter logic [7:0] BG_LUM    = 8'h60
) (
  input  logic          clk_vga,
  input  logic          rst,
  input  logic [5:0]    switch,
  input  logic [YW-1:0] pad_left,
  input  logic [YW-1:0] pad_right,
  input  logic [XW-1:0] ball_x,
  input  logic [YW-1:0] ball_y,
  output logic          frame_start,
  output logic          VGA_BLANK_N,
  output logic          VGA_HS,
  output logic          VGA_VS,
  output logic [CW-1:0] VGA_R,
  output logic [CW-1:0] VGA_G,
  output logic [CW-1:0] VGA_B
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HCW     = $clog2(H_TOTAL);
  localparam int VCW     = $clog2(V_TOTAL);
  localparam int XE      = XW + 1;
  localparam int YE      = YW + 1;

  localparam logic [HCW-1:0] H_LAST  = HCW'(H_TOTAL - 1);
  localparam logic [HCW-1:0] H_ACT   = HCW'(H_ACTIVE);
  localparam logic [HCW-1:0] HS_BEG  = HCW'(H_ACTIVE + H_FP);
  localparam logic [HCW-1:0] HS_END  = HCW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VCW-1:0] V_LAST  = VCW'(V_TOTAL - 1);
  localparam logic [VCW-1:0] V_ACT   = VCW'(V_ACTIVE);
  localparam logic [VCW-1:0] V_SNAP  = VCW'(V_ACTIVE - 1);
  localparam logic [VCW-1:0] VS_BEG  = VCW'(V_ACTIVE + V_FP);
  localparam logic [VCW-1:0] VS_END  = VCW'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [XE-1:0] X_LAST = XE'(H_ACTIVE - 1);
  localparam logic [XE-1:0] P1_LO  = XE'(PAD_DIST);
  localparam logic [XE-1:0] P1_HI  = XE'(PAD_DIST + PAD_W);
  localparam logic [XE-1:0] P2_LO  = XE'(H_ACTIVE - PAD_DIST - PAD_W);
  localparam logic [XE-1:0] P2_HI  = XE'(H_ACTIVE - PAD_DIST);
  localparam logic [XE-1:0] BH_X   = XE'(BALL_SIZE / 2);
  localparam logic [YE-1:0] Y_LAST = YE'(V_ACTIVE - 1);
  localparam logic [YE-1:0] PH     = YE'(PAD_H / 2);
  localparam logic [YE-1:0] BH_Y   = YE'(BALL_SIZE / 2);
`ifdef CENTER_NET_EN
  localparam logic [XE-1:0] NET_L  = XE'(H_ACTIVE / 2 - 1);
  localparam logic [XE-1:0] NET_R  = XE'(H_ACTIVE / 2);
`endif

  localparam logic [CW+7:0] BG_EXT = {BG_LUM, {CW{1'b0}}};
  localparam logic [CW-1:0] BG     = BG_EXT[CW+7 -: CW];

  logic [HCW-1:0] hc;
  logic [VCW-1:0] vc;
  logic [YW-1:0]  pl_s, pr_s, by_s;
  logic [XW-1:0]  bx_s;
  logic [5:0]     sw_s;
  logic           snap;

  assign snap = (hc == H_LAST) && (vc == V_SNAP);

  // Shadows only move at the end of the last visible line, so a frame never tears.
  always_ff @(posedge clk_vga or negedge rst) begin
    if (!rst) begin
      hc          <= '0;
      vc          <= '0;
      frame_start <= 1'b0;
      pl_s        <= YW'(V_ACTIVE / 2);
      pr_s        <= YW'(V_ACTIVE / 2);
      bx_s        <= XW'(H_ACTIVE / 2);
      by_s        <= YW'(V_ACTIVE / 2);
      sw_s        <= '0;
    end else begin
      if (hc == H_LAST) begin
        hc <= '0;
        vc <= (vc == V_LAST) ? '0 : vc + VCW'(1);
      end else begin
        hc <= hc + HCW'(1);
      end
      frame_start <= snap;
      if (snap) begin
        pl_s <= pad_left;
        pr_s <= pad_right;
        bx_s <= ball_x;
        by_s <= ball_y;
        sw_s <= switch;
      end
    end
  end

  logic [XE-1:0] x;
  logic [YE-1:0] y;
  logic          on_frame, on_pad1, on_pad2, on_ball, img, bg;

  assign x = XE'(hc);
  assign y = YE'(vc);

  assign on_frame = (x == '0) || (x == X_LAST) || (y == '0) || (y == Y_LAST);
  assign on_pad1  = (x > P1_LO) && (x < P1_HI) &&
                    (y + PH > YE'(pl_s)) && (y < YE'(pl_s) + PH);
  assign on_pad2  = (x > P2_LO) && (x < P2_HI) &&
                    (y + PH > YE'(pr_s)) && (y < YE'(pr_s) + PH);
  // Lower edge inclusive so the ball covers exactly BALL_SIZE pixels per axis.
  assign on_ball  = (x + BH_X >= XE'(bx_s)) && (x < XE'(bx_s) + BH_X) &&
                    (y + BH_Y >= YE'(by_s)) && (y < YE'(by_s) + BH_Y);
`ifdef CENTER_NET_EN
  assign img = on_frame | on_pad1 | on_pad2 | on_ball |
               (((x == NET_L) || (x == NET_R)) && !y[4]);
`else
  assign img = on_frame | on_pad1 | on_pad2 | on_ball;
`endif
  assign bg  = (sw_s[0] & (x[1] ^ y[1])) | (sw_s[1] & (x[4] ^ y[4]));

  logic act1, hs1, vs1, img1, bg1;

  always_ff @(posedge clk_vga or negedge rst) begin
    if (!rst) begin
      act1 <= 1'b0;
      hs1  <= 1'b0;
      vs1  <= 1'b0;
      img1 <= 1'b0;
      bg1  <= 1'b0;
    end else begin
      act1 <= (hc < H_ACT) && (vc < V_ACT);
      hs1  <= (hc >= HS_BEG) && (hc < HS_END);
      vs1  <= (vc >= VS_BEG) && (vc < VS_END);
      img1 <= img;
      bg1  <= bg;
    end
  end

  logic [CW-1:0] lum, fgp, bp, r_mix, g_mix, b_mix;

  always_comb begin
    lum = bg1 ? BG : '0;
    if (sw_s[5]) begin
      fgp = img1 ? '0 : '1;
      bp  = img1 ? lum : '0;
    end else begin
      fgp = img1 ? '1 : '0;
      bp  = lum;
    end
  end

  assign r_mix = sw_s[2] ? (bp | fgp) : fgp;
  assign g_mix = sw_s[3] ? (bp | fgp) : fgp;
  assign b_mix = sw_s[4] ? (bp | fgp) : fgp;

  always_ff @(posedge clk_vga or negedge rst) begin
    if (!rst) begin
      VGA_BLANK_N <= 1'b0;
      VGA_HS      <= !SYNC_POL;
      VGA_VS      <= !SYNC_POL;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
    end else begin
      VGA_BLANK_N <= act1;
      VGA_HS      <= hs1 ? SYNC_POL : !SYNC_POL;
      VGA_VS      <= vs1 ? SYNC_POL : !SYNC_POL;
      VGA_R       <= act1 ? r_mix : '0;
      VGA_G       <= act1 ? g_mix : '0;
      VGA_B       <= act1 ? b_mix : '0;
    end
  end

endmodule

// File: tb/tb_pong_renderer_gen2.sv
// tb/tb_pong_renderer_gen2.sv - directed bench for pong_renderer_gen2 on a reduced 64x48 raster
module tb_pong_renderer_gen2;

  localparam int HT = 80;
  localparam int FT = 4400;
  localparam logic [23:0] W = 24'hFFFFFF;
  localparam logic [23:0] K = 24'h000000;
`ifdef CENTER_NET_EN
  localparam logic [23:0] NET_EXP = 24'hFFFFFF;
`else
  localparam logic [23:0] NET_EXP = 24'h000000;
`endif

  logic       clk_vga = 1'b0;
  logic       rst;
  logic [5:0] switch;
  logic [8:0] pad_left, pad_right, ball_y;
  logic [9:0] ball_x;
  logic       frame_start, VGA_BLANK_N, VGA_HS, VGA_VS;
  logic [7:0] VGA_R, VGA_G, VGA_B;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int fs_cnt = 0;

  pong_renderer_gen2 #(
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(48), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .PAD_DIST(4), .PAD_W(4), .PAD_H(16), .BALL_SIZE(8)
  ) dut (
    .clk_vga(clk_vga), .rst(rst), .switch(switch),
    .pad_left(pad_left), .pad_right(pad_right), .ball_x(ball_x), .ball_y(ball_y),
    .frame_start(frame_start), .VGA_BLANK_N(VGA_BLANK_N), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
  );

  always #5 clk_vga = ~clk_vga;

  always @(posedge clk_vga or negedge rst)
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;

  always @(negedge clk_vga)
    if (rst && frame_start) fs_cnt <= fs_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic at_cyc(input int n);
    int spins = 0;
    while (cyc < n && spins < 50000) begin
      @(negedge clk_vga);
      spins++;
    end
    if (cyc != n) begin
      fails++;
      $display("FAIL timing cyc=%0d want=%0d", cyc, n);
    end
  endtask

  task automatic goto(input int f, input int x, input int y);
    at_cyc(f * FT + y * HT + x + 2);
  endtask

  task automatic pix(input string tag, input int f, input int x, input int y, input logic [23:0] exp);
    goto(f, x, y);
    check($sformatf("%s_f%0d(%0d,%0d)", tag, f, x, y), {8'h0, VGA_R, VGA_G, VGA_B}, {8'h0, exp});
  endtask

  initial begin
    rst = 1'b1;
    switch = 6'd0; pad_left = 9'd40; pad_right = 9'd10; ball_x = 10'd50; ball_y = 9'd30;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk_vga);
    check("rst_blank", VGA_BLANK_N, 1'b0);
    check("rst_hs", VGA_HS, 1'b1);
    check("rst_vs", VGA_VS, 1'b1);
    check("rst_rgb", {VGA_R, VGA_G, VGA_B}, K);
    check("rst_fs", frame_start, 1'b0);
    rst = 1'b1;

    // frame 0: reset shadows (pads 24, ball 32,24) regardless of inputs
    pix("border", 0, 0, 0, W);
    check("blank_act", VGA_BLANK_N, 1'b1);
    pix("border", 0, 63, 0, W);
    pix("hblank", 0, 64, 0, K);
    check("blank_h", VGA_BLANK_N, 1'b0);
    goto(0, 67, 0); check("hs_pre", VGA_HS, 1'b1);
    goto(0, 68, 0); check("hs_on", VGA_HS, 1'b0);
    goto(0, 75, 0); check("hs_last", VGA_HS, 1'b0);
    goto(0, 76, 0); check("hs_off", VGA_HS, 1'b1);
    pix("net", 0, 32, 5, NET_EXP);
    pix("bg", 0, 10, 10, K);
    pix("padl", 0, 6, 16, K);
    pix("padl", 0, 6, 17, W);
    pix("netgap", 0, 32, 18, K);
    pix("ball", 0, 32, 19, K);
    pix("ball", 0, 32, 20, W);
    goto(0, 0, 21);
    ball_x = 10'd20; ball_y = 9'd24; pad_left = 9'd0; pad_right = 9'd47;
    pix("padl", 0, 4, 24, K);
    pix("padl", 0, 5, 24, W);
    pix("padl", 0, 8, 24, K);
    pix("ball", 0, 27, 24, K);
    pix("ball", 0, 28, 24, W);
    pix("ball", 0, 35, 24, W);
    pix("ball", 0, 36, 24, K);
    pix("padr", 0, 56, 24, K);
    pix("padr", 0, 58, 24, W);
    pix("padr", 0, 60, 24, K);
    pix("ball", 0, 32, 27, W);
    pix("ball", 0, 32, 28, K);
    pix("padl", 0, 6, 31, W);
    pix("padl", 0, 6, 32, K);
    at_cyc(3839); check("fs_before", frame_start, 1'b0);
    at_cyc(3840); check("fs_pulse", frame_start, 1'b1);
    at_cyc(3841); check("fs_after", frame_start, 1'b0);
    pix("vblank", 0, 0, 48, K);
    check("blank_v", VGA_BLANK_N, 1'b0);
    goto(0, 0, 49);  check("vs_pre", VGA_VS, 1'b1);
    goto(0, 0, 50);  check("vs_on", VGA_VS, 1'b0);
    goto(0, 79, 51); check("vs_last", VGA_VS, 1'b0);
    goto(0, 0, 52);  check("vs_off", VGA_VS, 1'b1);

    // frame 1: ball_x 20, pad_left 0, pad_right 47
    pix("padl0", 1, 6, 7, W);
    pix("padl0", 1, 6, 8, K);
    pix("ball20", 1, 15, 24, K);
    pix("ball20", 1, 16, 24, W);
    pix("ballold", 1, 32, 24, K);
    pix("padr47", 1, 58, 39, K);
    pix("padl0", 1, 6, 40, K);
    pix("padr47", 1, 58, 40, W);
    pix("padr47", 1, 58, 46, W);
    goto(1, 0, 47); switch = 6'b100011;

    // frame 2: invert, no channel enables
    pix("inv_img", 2, 0, 10, K);
    pix("inv_bg", 2, 10, 10, W);
    pix("inv_blank", 2, 70, 10, K);
    check("inv_blank_n", VGA_BLANK_N, 1'b0);
    pix("inv_ball", 2, 16, 24, K);
    goto(2, 0, 47); switch = 6'b000101;

    // frame 3: fine checker on red only
    pix("fine_img", 3, 0, 12, W);
    pix("fine_off", 3, 8, 12, K);
    pix("fine_on", 3, 10, 12, 24'h600000);
    goto(3, 0, 47); switch = 6'b101010;

    // frame 4: coarse checker on green, inverted
    pix("cinv_img0", 4, 0, 10, K);
    pix("cinv_bg", 4, 10, 10, W);
    pix("cinv_img1", 4, 0, 16, 24'h006000);
    pix("cinv_bg", 4, 10, 20, W);
    check("fs_count", fs_cnt, 4);

    #2 rst = 1'b0;
    #1;
    check("arst_blank", VGA_BLANK_N, 1'b0);
    check("arst_hs", VGA_HS, 1'b1);
    check("arst_rgb", {VGA_R, VGA_G, VGA_B}, K);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
